ham_scrub_ctrl: RTL and testbench

HAM_SCRUB_CTRL -- requirements
Module: ham_scrub_ctrl

---
 rtl/ham_scrub_ctrl.sv | 132 +++++++++++++
 tb/tb_ham_scrub_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham_scrub_ctrl.sv
// Hamming scrub controller: READ/LOAD/WAIT/FIX per word (4+FIX_LAT-1 cycles), host access preempts only between words.
// HAM_SCRUB_WRITEBACK_EN compiles in writeback of corrected words; without it the pass is a read-only audit.
module ham_scrub_ctrl #(
    parameter int DEPTH   = 16,
    parameter int FIX_LAT = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       clr_cnt,
    input  logic                       host_req,
    output logic                       host_gnt,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    output logic                       mem_rd,
    input  logic [15:1]                mem_rdata,
    output logic                       mem_wr,
    output logic [15:1]                mem_wdata,
    output logic [15:1]                ham_out,
    input  logic [15:1]                ham_fixed,
    output logic [7:0]                 err_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, READ, LOAD, WAIT, FIX, DONE, HOST
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [2:0]    wait_cnt;
    logic          susp;
    logic          mismatch;
    logic          last;

    assign mismatch = (ham_fixed != ham_out);
    assign last     = (addr == AW'(DEPTH - 1));
    assign mem_addr = addr;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        host_gnt  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (host_req)   state_nxt = HOST;
                else if (start) state_nxt = READ;
            end
            READ: begin
                busy      = 1'b1;
                mem_rd    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == 3'd0) state_nxt = FIX;
            end
            FIX: begin
                busy = 1'b1;
`ifdef HAM_SCRUB_WRITEBACK_EN
                mem_wr    = mismatch;
                mem_wdata = ham_fixed;
`endif
                if (last)          state_nxt = DONE;
                else if (host_req) state_nxt = HOST;
                else               state_nxt = READ;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = host_req ? HOST : IDLE;
            end
            HOST: begin
                host_gnt = 1'b1;
                busy     = susp;
                if (!host_req) state_nxt = susp ? READ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // susp marks a pass parked in HOST so that release resumes at the next address
    always_ff @(posedge clock) begin
        if (reset) begin
            addr     <= '0;
            ham_out  <= '0;
            wait_cnt <= '0;
            susp     <= 1'b0;
        end else begin
            case (state)
                IDLE: addr <= '0;
                LOAD: begin
                    ham_out  <= mem_rdata;
                    wait_cnt <= 3'(FIX_LAT - 1);
                end
                WAIT: if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
                FIX: begin
                    if (!last) begin
                        addr <= addr + 1'b1;
                        if (host_req) susp <= 1'b1;
                    end
                end
                DONE: addr <= '0;
                HOST: if (!host_req) susp <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            err_count <= 8'd0;
        else if (clr_cnt)
            err_count <= 8'd0;
        else if (state == FIX && mismatch && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
endmodule

// File: tb/tb_ham_scrub_ctrl.sv
// Directed bench for ham_scrub_ctrl: behavioural memory plus a one-stage Hamming corrector.
module tb_ham_scrub_ctrl;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset, start, clr_cnt, host_req;
    logic        host_gnt, busy, done, mem_rd, mem_wr;
    logic [3:0]  mem_addr;
    logic [15:1] mem_rdata, mem_wdata, ham_out, ham_fixed;
    logic [7:0]  err_count;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:1] golden [0:DEPTH-1];
    logic [15:1] mem    [0:DEPTH-1];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_a = 4'd0;
    logic [15:1] ld_d = '0;
    int          rd_cnt = 0, wr_cnt = 0, wdnz_cnt = 0, done_cnt = 0;
    logic [3:0]  wr_log_a [0:63];
    logic [15:1] wr_log_d [0:63];

    ham_scrub_ctrl #(.DEPTH(DEPTH), .FIX_LAT(1)) dut (
        .clock(clock), .reset(reset), .start(start), .clr_cnt(clr_cnt),
        .host_req(host_req), .host_gnt(host_gnt), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .ham_out(ham_out),
        .ham_fixed(ham_fixed), .err_count(err_count)
    );

    always #5 clock = ~clock;

    function automatic logic [15:1] ham_correct(input logic [15:1] w);
        logic [3:0]  s;
        logic [15:1] r;
        s = 4'd0;
        r = w;
        for (int i = 1; i <= 15; i++) if (w[i]) s = s ^ 4'(i);
        if (s != 4'd0) r[s] = ~r[s];
        return r;
    endfunction

    always @(posedge clock) begin
        if (ld_en) mem[ld_a] <= ld_d;
        else if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
        ham_fixed <= ham_correct(ham_out);
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) begin
            wr_log_a[wr_cnt[5:0]] <= mem_addr;
            wr_log_d[wr_cnt[5:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_wdata != 15'd0) wdnz_cnt <= wdnz_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input int a, input logic [15:1] d);
        ld_en = 1'b1; ld_a = 4'(a); ld_d = d;
        tick();
        ld_en = 1'b0;
    endtask

    // corrupted entries get one bit flipped at position (a mod 15)+1
    task automatic load_mask(input logic [15:0] m);
        logic [15:1] f;
        int idx;
        for (int a = 0; a < DEPTH; a++) begin
            f = golden[a];
            idx = (a % 15) + 1;
            if (m[a]) f[idx] = ~f[idx];
            load_word(a, f);
        end
    endtask

    task automatic run_pass(output int cyc);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 300) begin tick(); n++; end
        cyc = done ? n : 0;
        tick();
    endtask

    task automatic wait_read(input logic [3:0] a, output bit ok);
        int n;
        n = 0;
        while (!(mem_rd && mem_addr == a) && n < 200) begin tick(); n++; end
        ok = mem_rd && mem_addr == a;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; clr_cnt = 1'b0; host_req = 1'b0;
        tick(); tick();
        n_chk++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_chk++; if (host_gnt !== 1'b0)   begin n_fail++; $display("FAIL reset_gnt: got %b want 0", host_gnt); end
        n_chk++; if (mem_rd !== 1'b0)     begin n_fail++; $display("FAIL reset_rd: got %b want 0", mem_rd); end
        n_chk++; if (mem_wr !== 1'b0)     begin n_fail++; $display("FAIL reset_wr: got %b want 0", mem_wr); end
        n_chk++; if (err_count !== 8'd0)  begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_count); end
        n_chk++; if (ham_out !== 15'd0)   begin n_fail++; $display("FAIL reset_ham: got %h want 0", ham_out); end
        n_chk++; if (mem_addr !== 4'd0)   begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_clean_pass();
        int n, r0, w0, d0;
        load_mask(16'h0000);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        start = 1'b1;
        tick();
        n = 1;
        while (!done && n < 300) begin
            start = (n == 10);
            tick(); n++;
        end
        start = 1'b0;
        n_chk++; if (n !== 65)              begin n_fail++; $display("FAIL clean_cycles: got %0d want 65", n); end
        n_chk++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL clean_busy_done: got %b want 1", busy); end
        n_chk++; if (rd_cnt - r0 !== 16)    begin n_fail++; $display("FAIL clean_reads: got %0d want 16", rd_cnt - r0); end
        n_chk++; if (err_count !== 8'd0)    begin n_fail++; $display("FAIL clean_err: got %0d want 0", err_count); end
        tick();
        n_chk++; if (done !== 1'b0)         begin n_fail++; $display("FAIL clean_done_pulse: got %b want 0", done); end
        repeat (5) tick();
        n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL clean_idle: got %b want 0", busy); end
        n_chk++; if (rd_cnt - r0 !== 16)    begin n_fail++; $display("FAIL clean_no_queue: got %0d reads want 16", rd_cnt - r0); end
        n_chk++; if (wr_cnt - w0 !== 0)     begin n_fail++; $display("FAIL clean_writes: got %0d want 0", wr_cnt - w0); end
        n_chk++; if (done_cnt - d0 !== 1)   begin n_fail++; $display("FAIL clean_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_correct();
        int cyc, w0;
        logic [15:1] f;
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        f = golden[3]; f[5] = ~f[5]; load_word(3, f);
        f = golden[9]; f[5] = ~f[5]; load_word(9, f);
        w0 = wr_cnt;
        run_pass(cyc);
        n_chk++; if (cyc !== 65)            begin n_fail++; $display("FAIL fix_cycles: got %0d want 65", cyc); end
        n_chk++; if (err_count !== 8'd2)    begin n_fail++; $display("FAIL fix_err1: got %0d want 2", err_count); end
`ifdef HAM_SCRUB_WRITEBACK_EN
        n_chk++; if (wr_cnt - w0 !== 2)     begin n_fail++; $display("FAIL fix_writes: got %0d want 2", wr_cnt - w0); end
        n_chk++; if (wr_log_a[w0[5:0]] !== 4'd3 || wr_log_d[w0[5:0]] !== golden[3])
            begin n_fail++; $display("FAIL fix_wr0: got a=%0d d=%h want a=3 d=%h", wr_log_a[w0[5:0]], wr_log_d[w0[5:0]], golden[3]); end
        n_chk++; if (wr_log_a[6'(w0 + 1)] !== 4'd9 || wr_log_d[6'(w0 + 1)] !== golden[9])
            begin n_fail++; $display("FAIL fix_wr1: got a=%0d d=%h want a=9 d=%h", wr_log_a[6'(w0 + 1)], wr_log_d[6'(w0 + 1)], golden[9]); end
`else
        n_chk++; if (wr_cnt - w0 !== 0)     begin n_fail++; $display("FAIL audit_writes: got %0d want 0", wr_cnt - w0); end
        n_chk++; if (wdnz_cnt !== 0)        begin n_fail++; $display("FAIL audit_wdata: got %0d nonzero cycles want 0", wdnz_cnt); end
`endif
        w0 = wr_cnt;
        run_pass(cyc);
`ifdef HAM_SCRUB_WRITEBACK_EN
        n_chk++; if (err_count !== 8'd2)    begin n_fail++; $display("FAIL fix_err2: got %0d want 2", err_count); end
`else
        n_chk++; if (err_count !== 8'd4)    begin n_fail++; $display("FAIL audit_err2: got %0d want 4", err_count); end
`endif
        n_chk++; if (wr_cnt - w0 !== 0)     begin n_fail++; $display("FAIL fix_writes2: got %0d want 0", wr_cnt - w0); end
        load_word(3, golden[3]);
        load_word(9, golden[9]);
    endtask

    task automatic test_host();
        int r0, d0, n;
        bit ok;
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        r0 = rd_cnt; d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        wait_read(4'd5, ok);
        n_chk++; if (!ok)                   begin n_fail++; $display("FAIL host_reach5: timeout"); end
        tick(); tick();
        n_chk++; if (ham_out !== golden[5]) begin n_fail++; $display("FAIL host_ham5: got %h want %h", ham_out, golden[5]); end
        host_req = 1'b1;
        tick();
        n_chk++; if (host_gnt !== 1'b0)     begin n_fail++; $display("FAIL host_gnt_fix: got %b want 0", host_gnt); end
        n_chk++; if (mem_addr !== 4'd5)     begin n_fail++; $display("FAIL host_addr_fix: got %0d want 5", mem_addr); end
        tick();
        n_chk++; if (host_gnt !== 1'b1)     begin n_fail++; $display("FAIL host_gnt: got %b want 1", host_gnt); end
        n_chk++; if (busy !== 1'b1)         begin n_fail++; $display("FAIL host_busy: got %b want 1", busy); end
        n_chk++; if (mem_addr !== 4'd6)     begin n_fail++; $display("FAIL host_addr: got %0d want 6", mem_addr); end
        repeat (3) tick();
        n_chk++; if (rd_cnt - r0 !== 6)     begin n_fail++; $display("FAIL host_quiet: got %0d reads want 6", rd_cnt - r0); end
        host_req = 1'b0;
        tick();
        n_chk++; if (mem_rd !== 1'b1 || mem_addr !== 4'd6)
            begin n_fail++; $display("FAIL host_resume: got rd=%b a=%0d want rd=1 a=6", mem_rd, mem_addr); end
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        n_chk++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL host_finish: timeout busy=%b", busy); end
        n_chk++; if (done_cnt - d0 !== 1)   begin n_fail++; $display("FAIL host_done_cnt: got %0d want 1", done_cnt - d0); end
        n_chk++; if (rd_cnt - r0 !== 16)    begin n_fail++; $display("FAIL host_reads: got %0d want 16", rd_cnt - r0); end
        // host request beats start when both arrive in IDLE
        start = 1'b1; host_req = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if (host_gnt !== 1'b1 || busy !== 1'b0)
            begin n_fail++; $display("FAIL host_prio: got gnt=%b busy=%b want gnt=1 busy=0", host_gnt, busy); end
        tick();
        host_req = 1'b0;
        r0 = rd_cnt;
        tick();
        n_chk++; if (host_gnt !== 1'b0)     begin n_fail++; $display("FAIL host_release: got %b want 0", host_gnt); end
        repeat (4) tick();
        n_chk++; if (rd_cnt - r0 !== 0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL host_start_dropped: got reads=%0d busy=%b want 0 0", rd_cnt - r0, busy); end
    endtask

    task automatic test_reset_mid();
        int r0, w0, d0;
        bit ok;
        load_mask(16'h0088);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_read(4'd7, ok);
        n_chk++; if (!ok)                   begin n_fail++; $display("FAIL rst_reach7: timeout"); end
        tick(); tick();
        n_chk++; if (err_count !== 8'd1)    begin n_fail++; $display("FAIL rst_pre_err: got %0d want 1", err_count); end
        w0 = wr_cnt; d0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || host_gnt !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_ctl: got busy=%b done=%b gnt=%b rd=%b wr=%b want all 0", busy, done, host_gnt, mem_rd, mem_wr); end
        n_chk++; if (err_count !== 8'd0 || ham_out !== 15'd0 || mem_addr !== 4'd0)
            begin n_fail++; $display("FAIL rst_mid_dat: got err=%0d ham=%h a=%0d want 0 0 0", err_count, ham_out, mem_addr); end
        r0 = rd_cnt;
        repeat (10) tick();
        n_chk++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_quiet: got reads=%0d writes=%0d busy=%b want 0 0 0", rd_cnt - r0, wr_cnt - w0, busy); end
        // reset while a pass is parked in HOST must discard the pass
        start = 1'b1; tick(); start = 1'b0;
        wait_read(4'd2, ok);
        tick(); tick();
        host_req = 1'b1;
        tick(); tick();
        n_chk++; if (host_gnt !== 1'b1 || busy !== 1'b1)
            begin n_fail++; $display("FAIL rst_host_pre: got gnt=%b busy=%b want 1 1", host_gnt, busy); end
        reset = 1'b1;
        tick();
        n_chk++; if (host_gnt !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rst_host: got gnt=%b busy=%b want 0 0", host_gnt, busy); end
        reset = 1'b0;
        r0 = rd_cnt;
        tick();
        n_chk++; if (host_gnt !== 1'b1 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rst_host_regrant: got gnt=%b busy=%b want 1 0", host_gnt, busy); end
        host_req = 1'b0;
        repeat (6) tick();
        n_chk++; if (rd_cnt - r0 !== 0 || busy !== 1'b0 || done_cnt - d0 !== 0)
            begin n_fail++; $display("FAIL rst_no_resume: got reads=%0d busy=%b dones=%0d want 0 0 0", rd_cnt - r0, busy, done_cnt - d0); end
        load_mask(16'h0000);
    endtask

    task automatic test_saturate();
        int cyc, bad, n;
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        bad = 0;
        for (int p = 0; p < 16; p++) begin
            load_mask(p < 15 ? 16'hFFFF : 16'h3FFF);
            run_pass(cyc);
            if (cyc != 65) bad++;
        end
        n_chk++; if (bad !== 0)             begin n_fail++; $display("FAIL sat_passes: got %0d bad passes want 0", bad); end
        n_chk++; if (err_count !== 8'd254)  begin n_fail++; $display("FAIL sat_preload: got %0d want 254", err_count); end
        load_mask(16'h0007);
        run_pass(cyc);
        n_chk++; if (err_count !== 8'd255)  begin n_fail++; $display("FAIL sat_255: got %0d want 255", err_count); end
        load_mask(16'h0001);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        n_chk++; if (err_count !== 8'd255 || mem_addr !== 4'd0)
            begin n_fail++; $display("FAIL sat_fix0: got err=%0d a=%0d want 255 0", err_count, mem_addr); end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_chk++; if (err_count !== 8'd0)    begin n_fail++; $display("FAIL sat_clr_prio: got %0d want 0", err_count); end
        n = 0;
        while (busy && n < 200) begin tick(); n++; end
        n_chk++; if (err_count !== 8'd0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL sat_after_clr: got err=%0d busy=%b want 0 0", err_count, busy); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) golden[i] = ham_correct(15'((i * 2731) ^ 16'h5A3C));
        test_reset();
        test_clean_pass();
        test_correct();
        test_host();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
